// File: rtl/data_mem_resp_pkg.sv
// data_mem_resp_pkg: shared state encoding, region bit and default sizes
package data_mem_resp_pkg;
  localparam int DATA_W = 32;
  localparam int MMIO_BIT = 31;
  localparam int DEFAULT_DEPTH = 1024;
  localparam int DEFAULT_LED_NUM = 16;
  localparam int DEFAULT_SW_NUM = 16;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
endpackage

// File: rtl/data_mem_resp_if.sv
// data_mem_resp_if: MEM-stage request/response bus
interface data_mem_resp_if;
  import data_mem_resp_pkg::*;
  logic mem_ce_i;
  logic mem_we_i;
  logic [DATA_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_data_i;
  logic [DATA_W-1:0] mem_data_o;
  logic stall_o;
  modport master(output mem_ce_i, mem_we_i, mem_addr_i, mem_data_i, input mem_data_o, stall_o);
  modport slave(input mem_ce_i, mem_we_i, mem_addr_i, mem_data_i, output mem_data_o, stall_o);
endinterface

// File: rtl/data_mem_resp_sram.sv
// dmem_sram: single-port synchronous RAM, 1-cycle read, write-first
module dmem_sram
  import data_mem_resp_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic en,
  input  logic we,
  input  logic [AW-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata <= wdata;
      end else rdata <= mem[addr];
    end
endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: data memory with LED/switch MMIO and a stalling read path
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int LED_NUM = DEFAULT_LED_NUM,
  parameter int SW_NUM = DEFAULT_SW_NUM
) (
  input  logic clk,
  input  logic rst,
  data_mem_resp_if.slave bus,
  input  logic [SW_NUM-1:0] switch_in,
  output logic [LED_NUM-1:0] led_out,
  output logic err_o
);
  localparam int AW = $clog2(DEPTH);
  logic [1:0] state;
  logic [SW_NUM-1:0] sw_meta, sw_sync;
  logic mmio_q, mis_q, accept, mis, mmio, unused_addr;
  logic [DATA_W-1:0] data_q, ram_rdata;
  assign accept = state == IDLE && bus.mem_ce_i;
  assign mis = |bus.mem_addr_i[1:0];
  assign mmio = bus.mem_addr_i[MMIO_BIT];
  assign bus.stall_o = (accept && !bus.mem_we_i) || state == RD;
  assign bus.mem_data_o = data_q;
  assign unused_addr = ^bus.mem_addr_i[MMIO_BIT-1:AW+2];
  dmem_sram #(.DEPTH(DEPTH)) u_sram (
    .clk(clk),
    .en(accept && !mis && !mmio),
    .we(bus.mem_we_i),
    .addr(bus.mem_addr_i[AW+1:2]),
    .wdata(bus.mem_data_i),
    .rdata(ram_rdata)
  );
  // data_q only changes on the RD->RESP edge, so the output holds between reads
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      sw_meta <= '0;
      sw_sync <= '0;
      mmio_q <= 1'b0;
      mis_q <= 1'b0;
      data_q <= '0;
      led_out <= '0;
      err_o <= 1'b0;
    end else begin
      sw_meta <= switch_in;
      sw_sync <= sw_meta;
      err_o <= err_o | (accept && mis);
      if (accept && bus.mem_we_i && !mis && mmio) led_out <= bus.mem_data_i[LED_NUM-1:0];
      if (accept && !bus.mem_we_i) begin
        mmio_q <= mmio;
        mis_q <= mis;
      end
      if (state == RD) data_q <= mis_q ? '0 : mmio_q ? DATA_W'(sw_sync) : ram_rdata;
      state <= (accept && !bus.mem_we_i) ? RD : state == RD ? RESP : IDLE;
    end
endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: directed self-checking bench for data_mem_resp
module tb_data_mem_resp;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] switch_in = '0;
  logic [15:0] led_out;
  logic err_o;
  int checks = 0;
  int errors = 0;
  data_mem_resp_if bus ();
  data_mem_resp dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .switch_in(switch_in),
    .led_out(led_out),
    .err_o(err_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
    bus.mem_ce_i = 1'b1;
    bus.mem_we_i = 1'b1;
    bus.mem_addr_i = addr;
    bus.mem_data_i = data;
    #1 chk({tag, "_wr_stall"}, 32'(bus.stall_o), 32'd0);
    tick();
    bus.mem_ce_i = 1'b0;
    bus.mem_we_i = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.mem_ce_i = 1'b1;
    bus.mem_we_i = 1'b0;
    bus.mem_addr_i = addr;
    #1 chk({tag, "_req_stall"}, 32'(bus.stall_o), 32'd1);
    tick();
    chk({tag, "_rd_stall"}, 32'(bus.stall_o), 32'd1);
    tick();
    chk({tag, "_resp_stall"}, 32'(bus.stall_o), 32'd0);
    chk({tag, "_resp_data"}, bus.mem_data_o, exp);
    bus.mem_ce_i = 1'b0;
    tick();
    chk({tag, "_hold_data"}, bus.mem_data_o, exp);
  endtask
  initial begin
    bus.mem_ce_i = 1'b0;
    bus.mem_we_i = 1'b0;
    bus.mem_addr_i = '0;
    bus.mem_data_i = '0;
    tick();
    tick();
    chk("rst_stall", 32'(bus.stall_o), 32'd0);
    chk("rst_data", bus.mem_data_o, 32'd0);
    chk("rst_led", 32'(led_out), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    rst = 1'b1;
    tick();
    wr("ram", 32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram", 32'h0000_0010, 32'hDEAD_BEEF);
    wr("led", 32'h8000_0000, 32'h0001_A5A5);
    chk("led_val", 32'(led_out), 32'h0000_A5A5);
    switch_in = 16'h00F0;
    tick();
    tick();
    tick();
    rd("sw", 32'h8000_0004, 32'h0000_00F0);
    wr("mis", 32'h0000_0012, 32'h0000_0001);
    chk("mis_err", 32'(err_o), 32'd1);
    rd("mis_word4", 32'h0000_0010, 32'hDEAD_BEEF);
    rd("mis_rd", 32'h0000_0013, 32'h0000_0000);
    chk("mis_err_sticky", 32'(err_o), 32'd1);
    chk("mis_led_kept", 32'(led_out), 32'h0000_A5A5);
    wr("b2b", 32'h0000_0020, 32'h1234_5678);
    bus.mem_ce_i = 1'b1;
    bus.mem_we_i = 1'b0;
    bus.mem_addr_i = 32'h0000_0020;
    #1 chk("b2b_req_stall", 32'(bus.stall_o), 32'd1);
    tick();
    chk("b2b_rd_stall", 32'(bus.stall_o), 32'd1);
    tick();
    chk("b2b_resp_data", bus.mem_data_o, 32'h1234_5678);
    bus.mem_we_i = 1'b1;
    bus.mem_data_i = 32'hFFFF_FFFF;
    #1 chk("b2b_resp_ignore_stall", 32'(bus.stall_o), 32'd0);
    tick();
    bus.mem_ce_i = 1'b0;
    bus.mem_we_i = 1'b0;
    rd("b2b_again", 32'h0000_0020, 32'h1234_5678);
    bus.mem_ce_i = 1'b1;
    bus.mem_we_i = 1'b0;
    bus.mem_addr_i = 32'h0000_0010;
    tick();
    chk("midrst_rd_stall", 32'(bus.stall_o), 32'd1);
    rst = 1'b0;
    bus.mem_ce_i = 1'b0;
    #1 chk("midrst_stall", 32'(bus.stall_o), 32'd0);
    chk("midrst_data", bus.mem_data_o, 32'd0);
    chk("midrst_err", 32'(err_o), 32'd0);
    chk("midrst_led", 32'(led_out), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("postrst_stall", 32'(bus.stall_o), 32'd0);
    chk("postrst_data", bus.mem_data_o, 32'd0);
    rd("postrst", 32'h0000_0010, 32'hDEAD_BEEF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
